// File: rtl/dsi_phy_pkg.sv
// Shared D-PHY definitions for the clock- and data-lane controllers:
// lane states, LP line level encodings, default timing and per-state outputs.
// Optional build macro: DSI_CLK_ULPS_EN adds the ultra-low-power states.
package dsi_phy_pkg;

    // Default timing in byte-clock cycles
    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned T_LPX_DEF     = 2;
    localparam int unsigned T_PREPARE_DEF = 2;
    localparam int unsigned T_ZERO_DEF    = 8;
    localparam int unsigned T_PRE_DEF     = 2;
    localparam int unsigned T_POST_DEF    = 8;
    localparam int unsigned T_TRAIL_DEF   = 2;
    localparam int unsigned T_EXIT_DEF    = 4;
    localparam int unsigned T_WAKEUP_DEF  = 16;

    // LP line levels, packed as {P, N}
    typedef logic [1:0] lp_lvl_t;
    localparam lp_lvl_t LP11 = 2'b11;
    localparam lp_lvl_t LP01 = 2'b01;
    localparam lp_lvl_t LP00 = 2'b00;
    localparam lp_lvl_t LP10 = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LPX    = 4'd1,
        ST_PREP   = 4'd2,
        ST_ZERO   = 4'd3,
        ST_PRE    = 4'd4,
        ST_RUN    = 4'd5,
        ST_POST   = 4'd6,
        ST_TRAIL  = 4'd7,
        ST_EXIT   = 4'd8
`ifdef DSI_CLK_ULPS_EN
        ,
        ST_U_ENT  = 4'd9,
        ST_ULPS   = 4'd10,
        ST_U_WAKE = 4'd11
`endif
    } clk_state_t;

    // Pad/PHY control bundle driven by the clock lane
    typedef struct packed {
        lp_lvl_t lp;
        logic    hs_hi_z;
        logic    hs_enable;
        logic    hs_ready;
`ifdef DSI_CLK_ULPS_EN
        logic    ulps_active;
`endif
    } clk_lane_out_t;

    // Output levels that apply while the lane sits in state s
    function automatic clk_lane_out_t clk_state_out(input clk_state_t s);
        clk_lane_out_t o;
        o.lp        = LP11;
        o.hs_hi_z   = 1'b1;
        o.hs_enable = 1'b0;
        o.hs_ready  = 1'b0;
`ifdef DSI_CLK_ULPS_EN
        o.ulps_active = 1'b0;
`endif
        case (s)
            ST_LPX:   o.lp = LP01;
            ST_PREP:  o.lp = LP00;
            ST_ZERO: begin
                o.lp      = LP00;
                o.hs_hi_z = 1'b0;
            end
            ST_PRE, ST_POST: begin
                o.lp        = LP00;
                o.hs_hi_z   = 1'b0;
                o.hs_enable = 1'b1;
            end
            ST_RUN: begin
                o.lp        = LP00;
                o.hs_hi_z   = 1'b0;
                o.hs_enable = 1'b1;
                o.hs_ready  = 1'b1;
            end
            ST_TRAIL: begin
                o.lp      = LP00;
                o.hs_hi_z = 1'b0;
            end
`ifdef DSI_CLK_ULPS_EN
            ST_U_ENT, ST_U_WAKE: o.lp = LP10;
            ST_ULPS: begin
                o.lp          = LP00;
                o.ulps_active = 1'b1;
            end
`endif
            default: o.lp = LP11;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dsi_lane_timer.sv
// Loadable down-counter used to time D-PHY lane states; stops at zero.
module dsi_lane_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    // Load on strobe, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/dsi_clk_lane_ctrl.sv
// DSI clock-lane controller: sequences LP-11 stop state into continuous HS
// clocking and back, with every D-PHY interval counted in byte clocks.
// Optional build macro: DSI_CLK_ULPS_EN adds ulps_req / T_WAKEUP and ULPS entry/exit.
module dsi_clk_lane_ctrl
    import dsi_phy_pkg::*;
#(
    parameter int unsigned T_LPX     = T_LPX_DEF,
    parameter int unsigned T_PREPARE = T_PREPARE_DEF,
    parameter int unsigned T_ZERO    = T_ZERO_DEF,
    parameter int unsigned T_PRE     = T_PRE_DEF,
    parameter int unsigned T_POST    = T_POST_DEF,
    parameter int unsigned T_TRAIL   = T_TRAIL_DEF,
    parameter int unsigned T_EXIT    = T_EXIT_DEF,
`ifdef DSI_CLK_ULPS_EN
    parameter int unsigned T_WAKEUP  = T_WAKEUP_DEF,
`endif
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic byte_clk,
    input  logic byte_rst_n,
    input  logic hs_req,
    input  logic data_busy,
`ifdef DSI_CLK_ULPS_EN
    input  logic ulps_req,
`endif
    output logic hs_ready,
    output logic busy,
    output logic lp_p,
    output logic lp_n,
    output logic hs_enable,
    output logic hs_hi_z,
    output logic ulps_active
);

    localparam clk_lane_out_t RST_OUT = clk_state_out(ST_IDLE);

    clk_state_t       r_state;
    clk_state_t       w_state_nxt;
    clk_lane_out_t    r_out;
    clk_lane_out_t    w_out_nxt;
    logic             r_busy;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tmr_zero;

    // Timer preload for a timed state: it lasts exactly T cycles
    function automatic logic [CNT_W-1:0] state_load(input clk_state_t s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            ST_LPX:    v = CNT_W'(T_LPX - 1);
            ST_PREP:   v = CNT_W'(T_PREPARE - 1);
            ST_ZERO:   v = CNT_W'(T_ZERO - 1);
            ST_PRE:    v = CNT_W'(T_PRE - 1);
            ST_POST:   v = CNT_W'(T_POST - 1);
            ST_TRAIL:  v = CNT_W'(T_TRAIL - 1);
            ST_EXIT:   v = CNT_W'(T_EXIT - 1);
`ifdef DSI_CLK_ULPS_EN
            ST_U_ENT:  v = CNT_W'(T_LPX - 1);
            ST_U_WAKE: v = CNT_W'(T_WAKEUP - 1);
`endif
            default:   v = '0;
        endcase
        return v;
    endfunction

    dsi_lane_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (byte_clk),
        .rst_n      (byte_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero_c   (w_tmr_zero)
    );

    // State register plus outputs registered alongside the state they belong to
    always_ff @(posedge byte_clk or negedge byte_rst_n) begin
        if (!byte_rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= RST_OUT;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state decode, timer reload on every state change, next outputs
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (hs_req) begin
                    w_state_nxt = ST_LPX;
`ifdef DSI_CLK_ULPS_EN
                end else if (ulps_req) begin
                    w_state_nxt = ST_U_ENT;
`endif
                end
            end
            ST_LPX:   if (w_tmr_zero) w_state_nxt = ST_PREP;
            ST_PREP:  if (w_tmr_zero) w_state_nxt = ST_ZERO;
            ST_ZERO:  if (w_tmr_zero) w_state_nxt = ST_PRE;
            ST_PRE:   if (w_tmr_zero) w_state_nxt = ST_RUN;
            ST_RUN:   if (!hs_req && !data_busy) w_state_nxt = ST_POST;
            ST_POST:  if (w_tmr_zero) w_state_nxt = ST_TRAIL;
            ST_TRAIL: if (w_tmr_zero) w_state_nxt = ST_EXIT;
            ST_EXIT:  if (w_tmr_zero) w_state_nxt = ST_IDLE;
`ifdef DSI_CLK_ULPS_EN
            ST_U_ENT:  if (w_tmr_zero) w_state_nxt = ST_ULPS;
            ST_ULPS:   if (!ulps_req) w_state_nxt = ST_U_WAKE;
            ST_U_WAKE: if (w_tmr_zero) w_state_nxt = ST_IDLE;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt != r_state) begin
            w_load     = 1'b1;
            w_load_val = state_load(w_state_nxt);
        end
        w_out_nxt = clk_state_out(w_state_nxt);
    end

    assign lp_p      = r_out.lp[1];
    assign lp_n      = r_out.lp[0];
    assign hs_hi_z   = r_out.hs_hi_z;
    assign hs_enable = r_out.hs_enable;
    assign hs_ready  = r_out.hs_ready;
    assign busy      = r_busy;
`ifdef DSI_CLK_ULPS_EN
    assign ulps_active = r_out.ulps_active;
`else
    assign ulps_active = 1'b0;
`endif

endmodule

// File: tb/tb_dsi_clk_lane_ctrl.sv
// Bench for dsi_clk_lane_ctrl: interval-based reference model plus directed literal checks.
// Honours DSI_CLK_ULPS_EN when the design is built with it.
module tb_dsi_clk_lane_ctrl;

    localparam int TLPX   = 2;
    localparam int TPREP  = 2;
    localparam int TZERO  = 8;
    localparam int TPRE   = 2;
    localparam int TPOST  = 8;
    localparam int TTRAIL = 2;
    localparam int TEXIT  = 4;
    localparam int TWAKE  = 16;

    // {lp_p, lp_n, hs_hi_z, hs_enable, hs_ready, busy, ulps_active}
    typedef logic [6:0] obs_t;
    localparam obs_t O_IDLE = 7'b1110000;

    logic byte_clk   = 1'b0;
    logic byte_rst_n = 1'b1;
    logic hs_req     = 1'b0;
    logic data_busy  = 1'b0;
    logic ulps_req   = 1'b0;
    logic hs_ready, busy, lp_p, lp_n, hs_enable, hs_hi_z, ulps_active;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: cycle index and start cycles of the active sequence (-1 = none)
    int m_cyc = 0;
    int m_s   = -1;  // first LPX cycle
    int m_p   = -1;  // first POST cycle
    int m_u   = -1;  // first ULPS-entry cycle
    int m_w   = -1;  // first wake cycle

    dsi_clk_lane_ctrl dut (
        .byte_clk    (byte_clk),
        .byte_rst_n  (byte_rst_n),
        .hs_req      (hs_req),
        .data_busy   (data_busy),
`ifdef DSI_CLK_ULPS_EN
        .ulps_req    (ulps_req),
`endif
        .hs_ready    (hs_ready),
        .busy        (busy),
        .lp_p        (lp_p),
        .lp_n        (lp_n),
        .hs_enable   (hs_enable),
        .hs_hi_z     (hs_hi_z),
        .ulps_active (ulps_active)
    );

    always #5 byte_clk = ~byte_clk;

    obs_t w_act;
    assign w_act = {lp_p, lp_n, hs_hi_z, hs_enable, hs_ready, busy, ulps_active};

    // Expected outputs in cycle n, from where n falls in the D-PHY intervals
    function automatic obs_t model_out(input int n);
        int k;
        if (m_u >= 0 && n >= m_u) begin
            if (m_w < 0 || n < m_w) begin
                k = n - m_u;
                return (k < TLPX) ? 7'b1010010 : 7'b0010011;
            end
            k = n - m_w;
            return (k < TWAKE) ? 7'b1010010 : O_IDLE;
        end
        if (m_s < 0 || n < m_s) return O_IDLE;
        if (m_p >= 0 && n >= m_p) begin
            k = n - m_p;
            if (k < TPOST)                  return 7'b0001010;
            if (k < TPOST + TTRAIL)         return 7'b0000010;
            if (k < TPOST + TTRAIL + TEXIT) return 7'b1110010;
            return O_IDLE;
        end
        k = n - m_s;
        if (k < TLPX)                         return 7'b0110010;
        if (k < TLPX + TPREP)                 return 7'b0010010;
        if (k < TLPX + TPREP + TZERO)         return 7'b0000010;
        if (k < TLPX + TPREP + TZERO + TPRE)  return 7'b0001010;
        return 7'b0001110;
    endfunction

    function automatic bit m_idle(input int n);
        obs_t o;
        o = model_out(n);
        return (o[1] == 1'b0);
    endfunction

    function automatic bit m_run(input int n);
        obs_t o;
        o = model_out(n);
        return (o[2] == 1'b1);
    endfunction

    function automatic bit m_ulps(input int n);
        obs_t o;
        o = model_out(n);
        return (o[0] == 1'b1);
    endfunction

    // Model advance on each clock edge using the inputs the DUT samples
    always @(posedge byte_clk or negedge byte_rst_n) begin
        if (!byte_rst_n) begin
            m_cyc <= 0;
            m_s   <= -1;
            m_p   <= -1;
            m_u   <= -1;
            m_w   <= -1;
        end else begin
            if (m_idle(m_cyc) && hs_req) begin
                m_s <= m_cyc + 1;
                m_p <= -1;
                m_u <= -1;
            end else if (m_idle(m_cyc) && ulps_req) begin
`ifdef DSI_CLK_ULPS_EN
                m_u <= m_cyc + 1;
                m_w <= -1;
                m_s <= -1;
`endif
            end else if (m_run(m_cyc) && !hs_req && !data_busy) begin
                m_p <= m_cyc + 1;
            end else if (m_ulps(m_cyc) && !ulps_req) begin
                m_w <= m_cyc + 1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge byte_clk) begin
        if (chk_on) begin
            obs_t e;
            e = byte_rst_n ? model_out(m_cyc) : O_IDLE;
            n_tests++;
            if (w_act !== e) begin
                n_fail++;
                $display("FAIL model cyc=%0d: got %b expected %b (lp_p lp_n hiz en rdy busy ulps)",
                         m_cyc, w_act, e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (m_cyc < c) @(negedge byte_clk);
    endtask

    function automatic int lp2();
        return int'({lp_p, lp_n});
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, x, d, p, c1;
        #2 byte_rst_n = 1'b0;
        repeat (3) @(negedge byte_clk);
        byte_rst_n = 1'b1;
        chk_on     = 1'b1;

        // Idle after reset release
        wait_to(19);
        chk("reset_vec", int'(w_act), int'(O_IDLE));
        chk("reset_busy", int'(busy), 0);

        // Startup timing from hs_req at cycle c0
        @(negedge byte_clk);
        c0 = m_cyc;
        hs_req = 1'b1;
        wait_to(c0 + 1);  chk("lp01_start", lp2(), 1);
        wait_to(c0 + 2);  chk("lp01_end", lp2(), 1);
        wait_to(c0 + 3);  chk("lp00_start", lp2(), 0);
        wait_to(c0 + 4);  chk("hiz_prep", int'(hs_hi_z), 1);
        wait_to(c0 + 5);  chk("hiz_zero", int'(hs_hi_z), 0);
        wait_to(c0 + 12); chk("en_before", int'(hs_enable), 0);
        wait_to(c0 + 13); chk("en_pre", int'(hs_enable), 1);
        wait_to(c0 + 14); chk("rdy_before", int'(hs_ready), 0);
        wait_to(c0 + 15); chk("rdy_run", int'(hs_ready), 1);

        // Stop request held off by data_busy
        wait_to(c0 + 16);
        x = m_cyc;
        hs_req    = 1'b0;
        data_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("rdy_hold", int'(hs_ready), 1);
            @(negedge byte_clk);
        end
        data_busy = 1'b0;
        d = m_cyc;
        chk("rdy_last_run", int'(hs_ready), 1);
        wait_to(d + 1);  chk("post_en", int'(hs_enable), 1);
        chk("post_rdy", int'(hs_ready), 0);
        wait_to(d + 8);  chk("post_en_end", int'(hs_enable), 1);
        wait_to(d + 9);  chk("trail_en", int'(hs_enable), 0);
        wait_to(d + 10); chk("trail_lp", lp2(), 0);
        wait_to(d + 11); chk("exit_lp11", lp2(), 3);
        wait_to(d + 14); chk("exit_busy", int'(busy), 1);
        wait_to(d + 15); chk("idle_busy", int'(busy), 0);

        // One-cycle request pulse, then re-request during POST
        repeat (3) @(negedge byte_clk);
        p = m_cyc;
        hs_req = 1'b1;
        @(negedge byte_clk);
        hs_req = 1'b0;
        wait_to(p + 15); chk("pulse_rdy", int'(hs_ready), 1);
        wait_to(p + 16); chk("pulse_post_rdy", int'(hs_ready), 0);
        chk("pulse_post_en", int'(hs_enable), 1);
        wait_to(p + 20);
        hs_req = 1'b1;
        wait_to(p + 29); chk("rereq_exit_busy", int'(busy), 1);
        wait_to(p + 30); chk("rereq_idle_busy", int'(busy), 0);
        chk("rereq_idle_lp", lp2(), 3);
        wait_to(p + 31); chk("rereq_lpx", lp2(), 1);
        wait_to(p + 45); chk("rereq_run", int'(hs_ready), 1);
        wait_to(p + 46);
        hs_req = 1'b0;
        wait_to(p + 60); chk("rereq_exit", int'(busy), 1);
        wait_to(p + 61); chk("rereq_done", int'(busy), 0);

        // Asynchronous reset during PRE
        repeat (2) @(negedge byte_clk);
        c1 = m_cyc;
        hs_req = 1'b1;
        wait_to(c1 + 13);
        chk("pre_en", int'(hs_enable), 1);
        #1 byte_rst_n = 1'b0;
        #1 chk("async_rst", int'(w_act[6:1]), int'(6'b111000));
        hs_req = 1'b0;
        @(negedge byte_clk);
        @(negedge byte_clk);
        byte_rst_n = 1'b1;
        repeat (5) @(negedge byte_clk);
        chk("after_rst", int'(w_act), int'(O_IDLE));

`ifdef DSI_CLK_ULPS_EN
        begin
            int u, w;
            @(negedge byte_clk);
            u = m_cyc;
            ulps_req = 1'b1;
            wait_to(u + 1); chk("uent_lp", lp2(), 2);
            wait_to(u + 2); chk("uent_lp2", lp2(), 2);
            wait_to(u + 3); chk("ulps_lp", lp2(), 0);
            chk("ulps_act", int'(ulps_active), 1);
            wait_to(u + 8);
            ulps_req = 1'b0;
            w = m_cyc;
            wait_to(w + 1);  chk("wake_lp", lp2(), 2);
            chk("wake_act", int'(ulps_active), 0);
            wait_to(w + 16); chk("wake_lp_end", lp2(), 2);
            wait_to(w + 17); chk("wake_idle_lp", lp2(), 3);
            chk("wake_idle_busy", int'(busy), 0);
        end
`endif

        repeat (3) @(negedge byte_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_clk_lane_ctrl.md
Name: dsi_clk_lane_ctrl

Overview:
- Sequences the DSI clock lane between low-power stop state and continuous high-speed clocking.
- Drives the LP line levels and the control inputs of the HS clock PHY (its enable and tri-state).
- Enforces D-PHY timing (TLPX, TCLK-PREPARE/ZERO/PRE/POST/TRAIL, THS-EXIT) in byte-clock cycles.
- Tells the data-lane controllers when the HS clock is usable. Sits between the packet scheduler and the clock-lane PHY.

Parameters:
- T_LPX, 2, cycles in LP-01 before LP-00
- T_PREPARE, 2, cycles in LP-00 with HS driver tri-stated
- T_ZERO, 8, cycles driving HS-0 before clocking
- T_PRE, 2, cycles of clock before hs_ready asserts
- T_POST, 8, cycles of clock after the stop request is accepted
- T_TRAIL, 2, cycles of HS-0 after the clock stops
- T_EXIT, 4, cycles in LP-11 before a new request is accepted
- CNT_W, 8, timing counter width; every T_* must be in 1..2^CNT_W-1

Ports:
- byte_clk  in  1  byte clock; the only clock
- byte_rst_n  in  1  asynchronous active-low reset
- hs_req  in  1  level request for the HS clock
- data_busy  in  1  OR of the data-lane HS-active flags; the clock must not stop while this is high
- hs_ready  out  1  HS clock running and stable; data lanes may enter HS
- busy  out  1  lane not in IDLE
- lp_p  out  1  LP driver level, P line
- lp_n  out  1  LP driver level, N line
- hs_enable  out  1  to the clock PHY enable input
- hs_hi_z  out  1  to the clock PHY tri-state control; 1 = HS driver off
- ulps_active  out  1  lane in ULPS (0 when the feature is compiled out)

Behaviour:
- Reset values: state=IDLE, lp_p=1, lp_n=1, hs_enable=0, hs_hi_z=1, hs_ready=0, busy=0, ulps_active=0. Counter=0.
- All outputs are registered. Each state output applies in the first cycle of that state.
- Every timed state lasts exactly T_x cycles. The counter loads T_x-1 on entry and the state advances when the counter reaches 0.
- State outputs (lp_p lp_n hs_hi_z hs_enable hs_ready):
  - IDLE 1 1 1 0 0
  - LPX 0 1 1 0 0
  - PREP 0 0 1 0 0
  - ZERO 0 0 0 0 0
  - PRE 0 0 0 1 0
  - RUN 0 0 0 1 1
  - POST 0 0 0 1 0
  - TRAIL 0 0 0 0 0
  - EXIT 1 1 1 0 0
- Transitions:
  - IDLE: hs_req=1 -> LPX.
  - LPX -> PREP -> ZERO -> PRE -> RUN, each after its timer expires.
  - RUN: hs_req=0 and data_busy=0 -> POST. If data_busy=1, stay in RUN with hs_ready held at 1.
  - POST -> TRAIL -> EXIT -> IDLE, each after its timer expires.
- hs_req changes are ignored outside IDLE and RUN; a started sequence always completes.
  - A request deasserted mid-startup still runs to RUN, then exits normally.
  - A request reasserted during POST, TRAIL or EXIT is serviced only once back in IDLE.
- The PHY registers its enable one byte_clk later. The downstream clock edge therefore lags hs_enable by 1 cycle. T_PRE and T_POST are counted from hs_enable, not from the pad.
- busy = (state != IDLE).
- Reset asserted mid-operation: immediately returns to the reset values, including LP-11 and HS tri-stated. There is no trail sequence.

Optional Feature:
- Macro: DSI_CLK_ULPS_EN.
- Defined:
  - Adds input ulps_req and parameter T_WAKEUP (default 16).
  - From IDLE, ulps_req=1 with hs_req=0 -> U_ENT (lp_p=1, lp_n=0) for T_LPX, then ULPS (lp 0 0, ulps_active=1).
  - ULPS holds until ulps_req=0 -> U_WAKE (lp 1 0) for T_WAKEUP -> IDLE.
  - hs_req has priority over ulps_req in IDLE.
- Not defined: no ulps_req port, ulps_active is tied to 0, and the ULPS states do not exist.

Decomposition:
- Shared package dsi_phy_pkg:
  - state enum
  - LP level constants LP11/LP01/LP00/LP10
  - default timing constants shared with the data-lane controller
- One natural sub-module: dsi_lane_timer. It is a loadable down-counter with load value, load strobe and a zero flag, and it is reused by the data-lane controller.

Test Plan:
- Reset release, hs_req=0 for 20 cycles -> outputs stay at their reset values, busy=0.
- hs_req rises at cycle 0 with default parameters:
  - lp goes 01 at cycle 1, 00 at cycle 3.
  - hs_hi_z=0 at cycle 5, hs_enable=1 at cycle 13, hs_ready=1 at cycle 15.
- In RUN, hs_req drops while data_busy=1 for 10 cycles:
  - hs_ready stays 1 throughout.
  - POST is entered the cycle after data_busy falls, hs_enable=0 8 cycles later, LP-11 2 cycles after that, busy=0 after a further 4.
- hs_req pulsed for 1 cycle in IDLE -> the full startup completes to RUN, then the lane immediately exits to IDLE.
- byte_rst_n asserted during PRE -> lp=11, hs_hi_z=1, hs_enable=0 asynchronously, before the next clock edge.
- With DSI_CLK_ULPS_EN: ulps_req=1 -> lp 10 for 2 cycles, then 00 with ulps_active=1. ulps_req=0 -> lp 10 for 16 cycles, then 11 and IDLE.
